// File: rtl/data_memory.sv
// data_memory: word-organised data RAM with an async clear, synchronous writes and combinational gated reads.
// Define DATAMEM_DEBUG_PORT_EN to add the DataMemory_0 output, which mirrors word 0.
module data_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Address_i,
    input  logic [31:0]       WriteData_i,
    input  logic              ReadEn_i,
    input  logic              WriteEn_i,
    output logic [31:0]       Data_o,
`ifdef DATAMEM_DEBUG_PORT_EN
    output logic [31:0]       DataMemory_0,
`endif
    output logic              Misalign_o
);
    localparam int IW = $clog2(DEPTH);
    logic [31:0]   mem [DEPTH];
    logic [IW-1:0] idx;
    logic          in_range;
    assign idx      = Address_i[IW+1:2];
    // Any address bit above the array span marks the access out of range, so indices never alias.
    assign in_range = (Address_i >> (IW + 2)) == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '{default: '0};
        else if (WriteEn_i && in_range)
            mem[idx] <= WriteData_i;
    end
    assign Data_o     = (ReadEn_i && in_range && !rst) ? mem[idx] : 32'h0;
    assign Misalign_o = (|Address_i[1:0]) && (ReadEn_i || WriteEn_i);
`ifdef DATAMEM_DEBUG_PORT_EN
    assign DataMemory_0 = mem[0];
`endif
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory.
// Stimulus changes 1ns after each rising edge; outputs are sampled a further 1ns later.
module tb_data_memory;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
    logic [31:0] data;
    logic        misalign;
    int          checks = 0;
    int          errors = 0;
`ifdef DATAMEM_DEBUG_PORT_EN
    logic [31:0] dbg0;
`endif

    data_memory #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .Address_i(addr),
        .WriteData_i(wdata),
        .ReadEn_i(ren),
        .WriteEn_i(wen),
        .Data_o(data),
`ifdef DATAMEM_DEBUG_PORT_EN
        .DataMemory_0(dbg0),
`endif
        .Misalign_o(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        ren  = 1'b1;
        #1;
        chk(tag, data, exp);
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; ren = 1'b1; wen = 1'b0;
        #2;
        chk("data_in_reset", data, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        rd("rd_0x0_after_reset", 32'h0, 32'h0);
        rd("rd_0x4_after_reset", 32'h4, 32'h0);
        rd("rd_0x3fc_after_reset", 32'h3FC, 32'h0);
        chk("misalign_aligned", {31'h0, misalign}, 32'h0);

        tick();
        addr = 32'h0; wdata = 32'hAE; wen = 1'b1; ren = 1'b0;
        #1;
        chk("data_during_write_ren0", data, 32'h0);
        tick();
        wen = 1'b0; ren = 1'b1; wdata = 32'hFF;
        #1;
        chk("rd_after_write_ae", data, 32'hAE);
        tick();
        chk("read_only_keeps_ae", data, 32'hAE);

        wen = 1'b1; wdata = 32'hDA;
        #1;
        chk("rw_same_before_edge", data, 32'hAE);
        tick();
        chk("rw_same_after_edge", data, 32'hDA);
`ifdef DATAMEM_DEBUG_PORT_EN
        chk("dbg_tracks_word0", dbg0, 32'hDA);
`endif

        addr = 32'h8; wdata = 32'h12345678; wen = 1'b1; ren = 1'b0;
        tick();
        wen = 1'b0;
        rd("rd_misaligned_0xa", 32'hA, 32'h12345678);
        chk("misalign_0xa", {31'h0, misalign}, 32'h1);
        rd("rd_aligned_0x8", 32'h8, 32'h12345678);
        chk("misalign_0x8", {31'h0, misalign}, 32'h0);
        addr = 32'hB; ren = 1'b0;
        #1;
        chk("misalign_idle", {31'h0, misalign}, 32'h0);
        chk("data_idle_zero", data, 32'h0);

        tick();
        addr = 32'h400; wdata = 32'hDEADBEEF; wen = 1'b1; ren = 1'b0;
        tick();
        wen = 1'b0;
        rd("rd_out_of_range", 32'h400, 32'h0);
        rd("word0_not_aliased", 32'h0, 32'hDA);
        rd("rd_far_out_of_range", 32'h0001_0000, 32'h0);

        tick();
        addr = 32'h3FC; wdata = 32'h55AA55AA; wen = 1'b1; ren = 1'b0;
        tick();
        wen = 1'b0;
        rd("rd_top_word", 32'h3FC, 32'h55AA55AA);

        tick();
        addr = 32'h4; wdata = 32'h11111111; wen = 1'b1; ren = 1'b0;
        tick();
        wen = 1'b0;
        rd("rd_word1_filled", 32'h4, 32'h11111111);
        #2;
        rst = 1'b1;
        #1;
        chk("word1_cleared_by_async_rst", data, 32'h0);
        rd("word0_cleared_by_async_rst", 32'h0, 32'h0);
`ifdef DATAMEM_DEBUG_PORT_EN
        chk("dbg_cleared_by_rst", dbg0, 32'h0);
`endif
        addr = 32'h10; wdata = 32'h77; wen = 1'b1;
        tick();
        wen = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        rd("write_blocked_in_reset", 32'h10, 32'h0);
        rd("word1_stays_cleared", 32'h4, 32'h0);
        rd("top_word_cleared", 32'h3FC, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
